// File: rtl/uart_tx_pkg.sv
// Shared types and parity encoding for the UART transmitter.
// Parity encoding matches the receiver so the two agree on the line format.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP1,
      STOP2
   } uart_tx_state_e;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   function automatic logic parity_bit(input logic [7:0] data, input logic parity_type);
      return (parity_type == PARITY_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Frame sequencer: walks START, 8 DATA bits, optional PARITY and 1-2 STOP bits,
// advancing one state per bit_done pulse.
module uart_tx_fsm
   import uart_tx_pkg::*;
(
   input  logic           clk_i,
   input  logic           srst_i,
   input  logic           start_i,
   input  logic           bit_done_i,
   input  logic           parity_en_i,
   input  logic           stop2_i,
   output uart_tx_state_e state_o,
   output logic           bit_last_o
);

   uart_tx_state_e state_q, state_d;
   logic [2:0]     idx_q, idx_d;
   logic           last_q, last_d;

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= IDLE;
         idx_q   <= 3'd0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE:   if (start_i) state_d = START;
         START:  if (bit_done_i) state_d = DATA;
         DATA: begin
            if (bit_done_i) begin
               if (last_q) begin
                  state_d = parity_en_i ? PARITY : STOP1;
                  idx_d   = 3'd0;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         PARITY: if (bit_done_i) state_d = STOP1;
         STOP1:  if (bit_done_i) state_d = stop2_i ? STOP2 : IDLE;
         STOP2:  if (bit_done_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Registered so the DATA exit decision does not depend on the index adder.
      last_d = (idx_d == 3'd7);
   end

   always_comb begin
      state_o    = state_q;
      bit_last_o = last_q;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte over valid/ready and serialises it LSB first
// with optional parity and one or two stop bits; tx_o and busy_o are registered.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned BitTicks = 16
) (
   input  logic       clk_i,
   input  logic       srst_i,
   input  logic [7:0] data_i,
   input  logic       data_valid_i,
   output logic       data_ready_o,
   input  logic       parity_en_i,
   input  logic       parity_type_i,
   input  logic       stop2_i,
   output logic       tx_o,
   output logic       busy_o
);

   localparam int unsigned   CntW   = (BitTicks > 1) ? $clog2(BitTicks) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(BitTicks - 1);

   uart_tx_state_e  state;
   logic            bit_last;
   logic            start;
   logic            bit_done;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      shift_q;
   logic            par_q;
   logic            pe_q;
   logic            s2_q;
   logic            tx_q, tx_d;
   logic            busy_q;

   always_comb begin
      data_ready_o = (state == IDLE) && !srst_i;
      start        = data_valid_i && data_ready_o;
      bit_done     = (state != IDLE) && (cnt_q == CntMax);
   end

   uart_tx_fsm u_fsm (
      .clk_i       (clk_i),
      .srst_i      (srst_i),
      .start_i     (start),
      .bit_done_i  (bit_done),
      .parity_en_i (pe_q),
      .stop2_i     (s2_q),
      .state_o     (state),
      .bit_last_o  (bit_last)
   );

   always_comb begin
      cnt_d = cnt_q;
      if (state == IDLE || bit_done) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Parity is taken from the whole byte at hand-off, before shifting starts.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         shift_q <= 8'h00;
         par_q   <= 1'b0;
         pe_q    <= 1'b0;
         s2_q    <= 1'b0;
      end else if (start) begin
         shift_q <= data_i;
         par_q   <= parity_bit(data_i, parity_type_i);
         pe_q    <= parity_en_i;
         s2_q    <= stop2_i;
      end else if (state == DATA && bit_done && !bit_last) begin
         shift_q <= {1'b0, shift_q[7:1]};
      end
   end

   always_comb begin
      tx_d = 1'b1;
      unique case (state)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         PARITY:  tx_d = par_q;
         STOP1:   tx_d = 1'b1;
         STOP2:   tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         busy_q <= (state != IDLE);
      end
   end

   always_comb begin
      tx_o   = tx_q;
      busy_o = busy_q;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serialises one byte per frame onto the UART line: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It is the transmit-side stage whose tx_o drives the line that the receiver samples on rx_i.
- Frame format and bit timing match the receiver: same BitTicks and same parity encoding, so tx_o looped into rx_i recovers the byte.
- Upstream (APB register or TX FIFO) hands bytes in over a valid/ready handshake.

Parameters:
BitTicks, 16, clk_i cycles per serial bit (>= 2); must equal the receiver's BitTicks.

Ports:
clk_i  input  1  system clock; all logic on rising edge
srst_i  input  1  synchronous active-high reset
data_i  input  8  byte to send; sampled on handshake
data_valid_i  input  1  upstream has a byte
data_ready_o  output  1  block can accept a byte this cycle
parity_en_i  input  1  1 = insert parity bit
parity_type_i  input  1  0 = even, 1 = odd
stop2_i  input  1  1 = two stop bits, 0 = one
tx_o  output  1  serial line; idle high
busy_o  output  1  frame in progress

Behaviour:
- Clock and reset: one clock, clk_i. Reset srst_i is synchronous and active-high.
- Reset values: tx_o=1, busy_o=0, state IDLE, tick counter 0, bit index 0.
- While srst_i=1: data_ready_o=0.
- Reset mid-frame: on the first edge with srst_i=1, tx_o returns to 1 and the frame is abandoned. No partial resume.
- Handshake:
  - data_ready_o = (state==IDLE) && !srst_i.
  - Transfer occurs when data_valid_i && data_ready_o on a rising edge.
  - data_i, parity_en_i, parity_type_i and stop2_i are latched at transfer. Later changes do not affect the current frame.
  - data_valid_i asserted while not ready is ignored; no byte is lost or duplicated.
- State machine (states IDLE, START, DATA, PARITY, STOP1, STOP2):
  - IDLE -> START on transfer.
  - START -> DATA.
  - DATA loops 8 bits using a 3-bit index.
  - DATA -> PARITY if latched parity_en, else -> STOP1.
  - PARITY -> STOP1.
  - STOP1 -> STOP2 if latched stop2, else -> IDLE.
  - STOP2 -> IDLE.
- Bit timing:
  - Every non-IDLE state lasts exactly BitTicks cycles.
  - Tick counter runs 0..BitTicks-1 and is held at 0 in IDLE.
  - A state change occurs on the edge where count==BitTicks-1.
- tx_o is registered. It goes low on the edge after the transfer edge.
- Line values per state: START=0; DATA = latched bit[index], LSB first; PARITY = ^data for even, ~^data for odd; STOP1/STOP2 = 1; IDLE = 1.
- busy_o = (state != IDLE), registered alongside tx_o.
- Frame length = BitTicks*(10 + P + S2) cycles of busy_o, where P = latched parity_en and S2 = latched stop2.
- Back-to-back frames: a byte presented continuously is accepted in the first IDLE cycle, giving exactly 1 idle-high cycle between frames.
- No glitches on tx_o; it changes only on bit boundaries.

Decomposition:
- Package uart_tx_pkg holds:
  - typedef uart_tx_state_e {IDLE, START, DATA, PARITY, STOP1, STOP2};
  - parity encoding constants PARITY_EVEN=0, PARITY_ODD=1, shared in meaning with the receiver.
- One sub-module, uart_tx_fsm:
  - Inputs: bit_done pulse, latched parity_en, latched stop2, start request.
  - Outputs: state, and bit_last, a registered flag set when the DATA index reaches 7.
- Top level holds the tick counter, data/config latches, parity compute and tx_o/busy_o registers.

Test Plan:
1. BitTicks=4, no parity, 1 stop, send 0x55 -> tx_o = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; busy_o high 40 cycles; data_ready_o high again on the next cycle.
2. parity_en=1, send 0xA3: even gives parity bit 0, odd gives 1; each frame lasts 44 cycles at BitTicks=4.
3. stop2_i=1, send 0x00 -> 8 zero data bits, then tx_o high 8 cycles before IDLE; busy_o 44 cycles. Toggling stop2_i mid-frame has no effect.
4. data_valid_i held high with 0x3C then 0x3D -> two frames separated by exactly 1 idle cycle; data_ready_o pulses exactly twice; no duplicate frame.
5. srst_i=1 for 1 cycle during data bit 3 -> tx_o=1 and busy_o=0 next cycle, data_ready_o=0 during reset; a new 0x81 frame afterwards is bit-exact.
6. Loopback: tx_o into the receiver's rx_i at BitTicks=16, odd parity, bytes 0x00, 0xFF, 0xC5 -> data_o matches each byte with a single data_valid_o pulse per frame.
